timer_rc_multi: RTL and testbench

- Multi-channel configurable-rate tick generator.
- One shared prescaler turns Clk into a base tick every PRESCALE cycles.
- NUM_CH independent channels count base ticks. Each channel fires a single-cycle Tick every (CfgValue+1) base ticks, in periodic or one-shot mode.
- Sits between the system clock and game/display logic (segment scroll rate, input debounce windows, timeouts), replacing one timer instance per rate.

---
 rtl/timer_rc_multi.sv | 82 ++++++++
 tb/tb_timer_rc_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_rc_multi.sv
// Multi-channel tick generator: one shared prescaler produces a base tick,
// and each channel fires a one-cycle Tick every (CfgValue+1) base ticks.
module timer_rc_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 10,
  parameter int PRESCALE = 50000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Enable,
  input  logic [NUM_CH-1:0]       ChEn,
  input  logic [NUM_CH-1:0]       Mode,
  input  logic [NUM_CH-1:0]       Clear,
  input  logic [NUM_CH*CNT_W-1:0] CfgValue,
  output logic [NUM_CH-1:0]       Tick,
  output logic [NUM_CH-1:0]       Done
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc;
  logic            base_tick;

  assign base_tick = Enable && (presc == PS_LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc <= '0;
    end else if (!Enable || base_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cfg;
    logic             tick_r;
    logic             done_r;
    logic             armed;
    logic             at_term;

    assign cfg     = CfgValue[i*CNT_W +: CNT_W];
    assign armed   = ChEn[i] && !(Mode[i] && done_r);
    assign at_term = (cnt >= cfg);

    // A base tick landing while Tick is still high (only possible with
    // PRESCALE=1) is held off one cycle so Tick can never stay high twice.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        done_r <= 1'b0;
      end else if (Clear[i]) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        done_r <= 1'b0;
      end else if (armed && base_tick) begin
        if (at_term && !tick_r) begin
          cnt    <= '0;
          tick_r <= 1'b1;
          if (Mode[i]) begin
            done_r <= 1'b1;
          end
        end else begin
          if (!at_term) begin
            cnt <= cnt + CNT_W'(1);
          end
          tick_r <= 1'b0;
        end
      end else begin
        tick_r <= 1'b0;
      end
    end

    assign Tick[i] = tick_r;
    assign Done[i] = done_r;
  end

endmodule

// File: tb/tb_timer_rc_multi.sv
// Bench for timer_rc_multi: directed cycle-exact scenarios plus a randomized
// run checked against a cycle-level behavioural model.
module tb_timer_rc_multi;

  localparam int PS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] chen = '0, mode = '0, clear = '0;
  logic [7:0] cfg = '0;
  logic [1:0] tick, done;

  logic       en2 = 1'b0, chen2 = 1'b0, mode2 = 1'b0, clear2 = 1'b0;
  logic [3:0] cfg2 = '0;
  logic       tick2, done2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // behavioural model of the PRESCALE=4 instance
  int         m_ps;
  int         m_cnt [2];
  logic [1:0] m_tick, m_done;

  timer_rc_multi #(.NUM_CH(2), .CNT_W(4), .PRESCALE(PS)) dut (
    .Clk(clk), .Rst(rst), .Enable(enable), .ChEn(chen), .Mode(mode),
    .Clear(clear), .CfgValue(cfg), .Tick(tick), .Done(done)
  );

  timer_rc_multi #(.NUM_CH(1), .CNT_W(4), .PRESCALE(1)) dut_p1 (
    .Clk(clk), .Rst(rst), .Enable(en2), .ChEn(chen2), .Mode(mode2),
    .Clear(clear2), .CfgValue(cfg2), .Tick(tick2), .Done(done2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ps = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_tick = '0;
    m_done = '0;
  endtask

  task automatic model_step();
    bit bt;
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    bt = enable && (m_ps == PS - 1);
    m_ps = enable ? (m_ps + 1) % PS : 0;
    for (int i = 0; i < 2; i++) begin
      c = int'(cfg[i*4 +: 4]);
      if (clear[i]) begin
        m_cnt[i] = 0; m_done[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (bt && chen[i] && !(mode[i] && m_done[i])) begin
        if (m_cnt[i] >= c && !m_tick[i]) begin
          m_cnt[i] = 0; m_tick[i] = 1'b1;
          if (mode[i]) m_done[i] = 1'b1;
        end else begin
          if (m_cnt[i] < c) m_cnt[i] = m_cnt[i] + 1;
          m_tick[i] = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
    end
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = '0;
    clear2 = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    enable = 1'b1; chen = 2'b11; mode = 2'b10; cfg = 8'h00;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tick !== 2'b00) begin
      n_fail++; $display("FAIL reset_tick actual=%b required=00", tick);
    end
    n_checks++;
    if (done !== 2'b00) begin
      n_fail++; $display("FAIL reset_done actual=%b required=00", done);
    end
  endtask

  task automatic test_periodic();
    logic [1:0] exp;
    enable = 1'b1; chen = 2'b01; mode = 2'b00; cfg = {4'd3, 4'd2};
    do_reset();
    n_checks++;
    if (tick !== 2'b00) begin
      n_fail++; $display("FAIL periodic_c0 actual=%b required=00", tick);
    end
    while (cyc < 40) begin
      tick_clk();
      exp = {1'b0, (cyc == 12) || (cyc == 24) || (cyc == 36)};
      n_checks++;
      if (tick !== exp) begin
        n_fail++; $display("FAIL periodic cyc=%0d actual=%b required=%b", cyc, tick, exp);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [1:0] et, ed;
    enable = 1'b1; chen = 2'b10; mode = 2'b10; cfg = {4'd1, 4'd0};
    do_reset();
    while (cyc < 120) begin
      clear = (cyc == 108) ? 2'b10 : 2'b00;
      tick_clk();
      et = {(cyc == 8) || (cyc == 116), 1'b0};
      ed = {(cyc >= 8 && cyc <= 108) || (cyc >= 116), 1'b0};
      n_checks++;
      if (tick !== et || done !== ed) begin
        n_fail++;
        $display("FAIL oneshot cyc=%0d actual tick=%b done=%b required tick=%b done=%b",
                 cyc, tick, done, et, ed);
      end
    end
    clear = '0;
  endtask

  task automatic test_clear_vs_basetick();
    logic [1:0] exp;
    enable = 1'b1; chen = 2'b01; mode = 2'b00; cfg = {4'd0, 4'd2};
    do_reset();
    while (cyc < 30) begin
      clear = (cyc == 11) ? 2'b01 : 2'b00;
      tick_clk();
      exp = {1'b0, cyc == 24};
      n_checks++;
      if (tick !== exp) begin
        n_fail++; $display("FAIL clear_vs_bt cyc=%0d actual=%b required=%b", cyc, tick, exp);
      end
    end
    clear = '0;
  endtask

  task automatic test_pause_cfg();
    logic [1:0] exp;
    enable = 1'b1; chen = 2'b01; mode = 2'b00; cfg = {4'd0, 4'd5};
    do_reset();
    while (cyc < 60) begin
      chen[0] = !(cyc >= 12 && cyc < 22);
      cfg[3:0] = (cyc >= 44) ? 4'd1 : 4'd5;
      tick_clk();
      exp = {1'b0, (cyc == 32) || (cyc == 48) || (cyc == 56)};
      n_checks++;
      if (tick !== exp) begin
        n_fail++; $display("FAIL pause_cfg cyc=%0d actual=%b required=%b", cyc, tick, exp);
      end
    end
  endtask

  task automatic test_enable_prescale1();
    logic [1:0] exp;
    logic       exp2, prev2;
    enable = 1'b0; chen = 2'b01; mode = 2'b00; cfg = 8'h00;
    en2 = 1'b0; chen2 = 1'b1; mode2 = 1'b0; cfg2 = 4'd0;
    do_reset();
    prev2 = 1'b0;
    while (cyc < 30) begin
      enable = (cyc >= 10);
      en2 = (cyc >= 10);
      tick_clk();
      exp = {1'b0, (cyc >= 14) && ((cyc - 14) % 4 == 0)};
      exp2 = (cyc >= 11) && ((cyc - 11) % 2 == 0);
      n_checks++;
      if (tick !== exp) begin
        n_fail++; $display("FAIL enable_gate cyc=%0d actual=%b required=%b", cyc, tick, exp);
      end
      n_checks++;
      if (tick2 !== exp2) begin
        n_fail++; $display("FAIL ps1_tick cyc=%0d actual=%b required=%b", cyc, tick2, exp2);
      end
      n_checks++;
      if (prev2 && tick2) begin
        n_fail++; $display("FAIL ps1_double cyc=%0d actual=11 required=not 11", cyc);
      end
      prev2 = tick2;
    end
    en2 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [1:0] et, ed;
    enable = 1'b1; chen = 2'b11; mode = 2'b10; cfg = {4'd1, 4'd2};
    do_reset();
    while (cyc < 8) tick_clk();
    n_checks++;
    if (tick !== 2'b10 || done !== 2'b10) begin
      n_fail++; $display("FAIL pre_async cyc=8 actual tick=%b done=%b required tick=10 done=10", tick, done);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (tick !== 2'b00 || done !== 2'b00) begin
      n_fail++; $display("FAIL async_reset actual tick=%b done=%b required tick=00 done=00", tick, done);
    end
    #1;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 16) begin
      tick_clk();
      et = {cyc == 8, cyc == 12};
      ed = {cyc >= 8, 1'b0};
      n_checks++;
      if (tick !== et || done !== ed) begin
        n_fail++;
        $display("FAIL after_async cyc=%0d actual tick=%b done=%b required tick=%b done=%b",
                 cyc, tick, done, et, ed);
      end
    end
  endtask

  task automatic test_random();
    enable = 1'b1; chen = 2'b11; mode = 2'b00; cfg = {4'd2, 4'd1};
    do_reset();
    for (int n = 0; n < 800; n++) begin
      enable = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < 2; i++) begin
        chen[i]  = ($urandom_range(0, 9) != 0);
        clear[i] = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        cfg[3:0] = 4'($urandom_range(0, 6));
        cfg[7:4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      end
      tick_clk();
      n_checks++;
      if (tick !== m_tick || done !== m_done) begin
        n_fail++;
        $display("FAIL random cyc=%0d actual tick=%b done=%b required tick=%b done=%b",
                 cyc, tick, done, m_tick, m_done);
      end
    end
    clear = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_oneshot();
    test_clear_vs_basetick();
    test_pause_cfg();
    test_enable_prescale1();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
